// File: rtl/crypto_decoder.sv
// -----------------------------------------------------------------------------
// crypto_decoder
//
// Sequential 4-round decryptor for the 32-bit round cipher. One ciphertext word
// and its 32-bit key are accepted through a valid/ready handshake. The four
// inverse rounds are applied in descending order (3, 2, 1, 0), one per clock.
// The plaintext is then presented through a valid/ready output handshake.
//
// Inverse round i, where rk_i = rotl(key, 8*i):
//     x = rotr(x - rk_i, 5) ^ rk_i      (32-bit wrap-around subtraction)
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A producer holds valid, and its data/key, stable until that transfer.
//   Ready never depends on valid.
//   Input side: in_ready is high only in IDLE and only while rst is low.
//   Output side: out_valid and out_data stay stable in DONE until out_ready.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   upstream offers in_data/in_key
//   in_ready   out  1   decoder idle and able to accept
//   in_data    in   32  ciphertext
//   in_key     in   32  cipher key, sampled together with in_data
//   out_valid  out  1   out_data holds plaintext
//   out_ready  in   1   downstream accepts out_data
//   out_data   out  32  plaintext
//   busy       out  1   high while in ROUND or DONE
//   round_idx  out  2   round applied at the next edge; 0 outside ROUND
//   blk_count  out  16  completed output handshakes (CRYPTO_DEC_CNT_EN only)
//
// Build option:
//   CRYPTO_DEC_CNT_EN - when defined, adds the blk_count port and its counter.
// -----------------------------------------------------------------------------
module crypto_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [1:0]  round_idx
`ifdef CRYPTO_DEC_CNT_EN
    ,
    output logic [15:0] blk_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] data_q;
    logic [31:0] key_q;
    logic [1:0]  round_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;

    logic [31:0] round_key_d;
    logic [31:0] data_d;

    // Round key i is the cipher key rotated left by whole bytes.
    function automatic logic [31:0] round_key(input logic [31:0] key,
                                              input logic [1:0]  idx);
        logic [31:0] rk;
        case (idx)
            2'd0:    rk = key;
            2'd1:    rk = {key[23:0], key[31:24]};
            2'd2:    rk = {key[15:0], key[31:16]};
            default: rk = {key[7:0],  key[31:8]};
        endcase
        return rk;
    endfunction

    // Undo one forward round: subtract the round key (borrow discarded),
    // rotate right by 5, then strip the XOR with the round key.
    function automatic logic [31:0] inverse_round(input logic [31:0] x,
                                                  input logic [31:0] rk);
        logic [31:0] diff;
        diff = x - rk;
        return {diff[4:0], diff[31:5]} ^ rk;
    endfunction

    always_comb begin
        round_key_d = round_key(key_q, round_q);
        data_d      = inverse_round(data_q, round_key_d);
    end

    // Control and datapath FSM. Every output is registered here except
    // in_ready, which must drop in the same cycle rst is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= 32'd0;
            key_q       <= 32'd0;
            round_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        key_q   <= in_key;
                        round_q <= 2'd3;
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    data_q <= data_d;
                    if (round_q == 2'd0) begin
                        // The last round result goes straight to the output
                        // register, so out_valid rises on the same edge.
                        out_data_q  <= data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        round_q <= round_q - 2'd1;
                    end
                end
                S_DONE: begin
                    // New input is not taken this cycle; IDLE comes first.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    // round_q is 0 when leaving ROUND, but gating keeps the output defined
    // as 0 in every non-ROUND state regardless.
    assign round_idx = (state_q == S_ROUND) ? round_q : 2'd0;

`ifdef CRYPTO_DEC_CNT_EN
    logic [15:0] blk_count_q;

    // Free-running 16-bit count of output transfers; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_q <= 16'd0;
        end else if (out_valid_q && out_ready) begin
            blk_count_q <= blk_count_q + 16'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_crypto_decoder.sv
// -----------------------------------------------------------------------------
// tb_crypto_decoder
//
// Self-checking bench for crypto_decoder. The reference model is the cipher
// definition itself: an encrypt function (rounds 0..3) and a decrypt function
// (rounds 3..0) written with plain shifts and arithmetic.
// -----------------------------------------------------------------------------
module tb_crypto_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [1:0]  round_idx;
`ifdef CRYPTO_DEC_CNT_EN
    logic [15:0] blk_count;
    int unsigned exp_cnt;
`endif

    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] exp_q[$];

    crypto_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
`ifdef CRYPTO_DEC_CNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] m_encrypt(input logic [31:0] p, input logic [31:0] k);
        logic [31:0] x;
        logic [31:0] rk;
        x = p;
        for (int i = 0; i < 4; i++) begin
            rk = m_rotl(k, 8 * i);
            x  = m_rotl(x ^ rk, 5) + rk;
        end
        return x;
    endfunction

    function automatic logic [31:0] m_decrypt(input logic [31:0] c, input logic [31:0] k);
        logic [31:0] x;
        logic [31:0] rk;
        x = c;
        for (int i = 3; i >= 0; i--) begin
            rk = m_rotl(k, 8 * i);
            x  = m_rotl(x - rk, 27) ^ rk;
        end
        return x;
    endfunction

    // Advance one cycle and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full decode. hold == 0: out_ready high throughout.
    // hold > 0: out_ready low for hold cycles once out_valid is seen, then raised.
    task automatic do_decode(input logic [31:0] c, input logic [31:0] k,
                             input logic [31:0] exp, input int hold,
                             input bit chk_idx, input string name);
        int lat;
        int waited;
        logic [1:0] idx_seen[4];
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL %s in_ready_wait: in_ready=%b required 1", name, in_ready);
        end
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = c;
        in_key    = k;
        tick();
        in_valid  = 1'b0;
        // Garbage after acceptance must not affect the result.
        in_data   = $urandom;
        in_key    = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) idx_seen[lat] = round_idx;
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL %s latency: got %0d required 4", name, lat);
        end
        if (chk_idx) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (idx_seen[i] !== 2'(3 - i)) begin
                    n_err++;
                    $display("FAIL %s round_idx[%0d]: got %0d required %0d",
                             name, i, idx_seen[i], 3 - i);
                end
            end
        end
        n_cmp++;
        if (out_data !== exp) begin
            n_err++;
            $display("FAIL %s out_data: got %h required %h", name, out_data, exp);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s backpressure cyc %0d: out_valid=%b out_data=%h in_ready=%b required 1 %h 0",
                         name, i, out_valid, out_data, in_ready, exp);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     name, out_valid, in_ready, busy);
        end
`ifdef CRYPTO_DEC_CNT_EN
        exp_cnt = exp_cnt + 1;
        n_cmp++;
        if (blk_count !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL %s blk_count: got %0d required %0d", name, blk_count, 16'(exp_cnt));
        end
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;          // reset must win over a pending input
        in_data   = 32'h1234_5678;
        in_key    = 32'h9ABC_DEF0;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || busy !== 1'b0 ||
            round_idx !== 2'd0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: ov=%b od=%h busy=%b ri=%0d ir=%b required 0 0 0 0 0",
                     out_valid, out_data, busy, round_idx, in_ready);
        end
`ifdef CRYPTO_DEC_CNT_EN
        exp_cnt = 0;
        n_cmp++;
        if (blk_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_blk_count: got %0d required 0", blk_count);
        end
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_known_vectors();
        do_decode(32'h0000_0001, 32'h0, 32'h0000_1000, 0, 1'b0, "vec_one");
        do_decode(32'hDEAD_BEEF, 32'h0, 32'hDBEE_FDEA, 0, 1'b1, "vec_deadbeef");
    endtask

    task automatic test_round_trip();
        logic [31:0] c;
        c = m_encrypt(32'hDEAD_BEEF, 32'hC0FF_EEEE);
        do_decode(c, 32'hC0FF_EEEE, 32'hDEAD_BEEF, 0, 1'b1, "rt_deadbeef");
        c = m_encrypt(32'h1C02_5000, 32'hC0FF_EEEE);
        do_decode(c, 32'hC0FF_EEEE, 32'h1C02_5000, 0, 1'b0, "rt_1c025000");
    endtask

    task automatic test_random();
        logic [31:0] p;
        logic [31:0] k;
        logic [31:0] c;
        logic [31:0] e;
        for (int n = 0; n < 1000; n++) begin
            p = $urandom;
            k = $urandom;
            c = m_encrypt(p, k);
            exp_q.push_back(m_decrypt(c, k));
            e = exp_q.pop_front();
            n_cmp++;
            if (e !== p) begin
                n_err++;
                $display("FAIL model_round_trip: got %h required %h", e, p);
            end
            do_decode(c, k, p, $urandom_range(0, 2), 1'b0, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] k;
        k = $urandom;
        do_decode(m_encrypt(32'hA5A5_0F0F, k), k, 32'hA5A5_0F0F, 10, 1'b0, "backpressure");
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        logic [31:0] k;
        for (int n = 0; n < 8; n++) begin
            p = $urandom;
            k = $urandom;
            do_decode(m_encrypt(p, k), k, p, 0, 1'b0, "back_to_back");
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] p;
        logic [31:0] k;
        int seen_ov;
        p = $urandom;
        k = $urandom;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = m_encrypt(p, k);
        in_key    = k;
        tick();                     // accepted; round_idx = 3
        in_valid = 1'b0;
        tick();                     // round_idx = 2
        tick();                     // round_idx = 1
        n_cmp++;
        if (round_idx !== 2'd1) begin
            n_err++;
            $display("FAIL mid_reset_setup round_idx: got %0d required 1", round_idx);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_state: busy=%b ov=%b ir=%b required 0 0 0",
                     busy, out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_in_ready: got %b required 1", in_ready);
        end
`ifdef CRYPTO_DEC_CNT_EN
        exp_cnt = 0;
`endif
        seen_ov = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen_ov++;
        end
        n_cmp++;
        if (seen_ov != 0) begin
            n_err++;
            $display("FAIL mid_reset_no_output: out_valid cycles %0d required 0", seen_ov);
        end
        out_ready = 1'b0;
        do_decode(m_encrypt(p, k), k, p, 0, 1'b1, "after_reset");
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_key    = 32'd0;
        out_ready = 1'b0;
`ifdef CRYPTO_DEC_CNT_EN
        exp_cnt   = 0;
`endif
        test_reset();
        test_known_vectors();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crypto_decoder.md
# crypto_decoder

Sequential 4-round decryptor for the team's 32-bit round cipher. Accepts one ciphertext word plus 32-bit key through a valid/ready input handshake, applies the four inverse rounds in descending round order (one round per clock), and presents the plaintext through a valid/ready output handshake. It is the receive-side counterpart of the encrypting cryptography module and recovers any word that module produced over rounds 0..3 with the same key.

## Interface
- No parameters. Data and key width are fixed at 32 bits, and the round count is fixed at 4.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a ciphertext word and key.
- in_ready  output  1  decoder can accept input; equals (state==IDLE && !rst).
- in_data  input  32  ciphertext.
- in_key  input  32  cipher key, sampled together with in_data.
- out_valid  output  1  out_data holds valid plaintext.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  32  plaintext.
- busy  output  1  high in ROUND and DONE.
- round_idx  output  2  index of the round applied at the next edge; 0 outside ROUND.
- blk_count  output  16  completed output handshakes. Present only with CRYPTO_DEC_CNT_EN.

## Operation
- Round key: rk_i = rotl(key, 8*i), i = 0..3.
- Forward round, for reference modelling: x = rotl(x ^ rk_i, 5) + rk_i (mod 2^32).
- Inverse round applied by this block: x = rotr(x − rk_i, 5) ^ rk_i. The subtraction is 32-bit with wrap-around, and the borrow is discarded.
- Round order: i = 3, 2, 1, 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_data into the state register, latch in_key into the key register, set round_idx = 3, and go to ROUND.
- ROUND:
  - Each edge: state = inverse_round(state, rk_round_idx).
  - If round_idx == 0, go to DONE; otherwise decrement round_idx.
  - in_data and in_key are ignored.
- DONE:
  - out_valid = 1 and out_data = state, both held stable.
  - On out_valid && out_ready: go to IDLE and drop out_valid.
  - No new input is accepted in the same cycle; there is no overlap.
- in_data and in_key changing after acceptance have no effect.
- in_valid while busy is not consumed. Upstream must hold it until in_ready.

## Timing
- Reset values: out_valid = 0, out_data = 0, busy = 0, round_idx = 0, blk_count = 0, state = IDLE.
- in_ready is 0 while rst is high and 1 in the first cycle after reset is released.
- Latency:
  - Input accepted at edge N.
  - Rounds 3, 2, 1, 0 are applied at edges N+1..N+4.
  - out_valid is high from edge N+4.
- Minimum spacing between accepts is 6 cycles, reached with out_ready held high: accept, 4 rounds, DONE, IDLE.
- out_ready held low: DONE persists indefinitely with out_data stable. Backpressure never corrupts data.
- out_ready high before out_valid has no effect.
- Reset mid-operation, in any state: the next edge forces IDLE. The in-flight word is discarded, and no out_valid pulse is emitted.
- rst and in_valid high in the same cycle: reset wins, and the input is not accepted.

## Configuration
- CRYPTO_DEC_CNT_EN:
  - Defined: adds the blk_count output, which increments on each out_valid && out_ready.
  - blk_count wraps from 0xFFFF to 0x0000 and is cleared by rst.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- in_data = 0x0000_0001, in_key = 0, out_ready = 1 → out_data = 0x0000_1000, out_valid first high 4 cycles after accept.
- in_data = 0xDEAD_BEEF, in_key = 0 → out_data = 0xDBEE_FDEA. Meanwhile round_idx reads 3, 2, 1, 0 on successive ROUND cycles.
- Round trip:
  - Plaintext 0xDEAD_BEEF and 0x1C02_5000 with key 0xC0FF_EEEE, forward-encrypted by the bench model.
  - Decoding each ciphertext returns the original plaintext.
  - 1000 random data/key pairs also match.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid → out_data stable and in_ready = 0 throughout.
  - Raising out_ready → out_valid drops next edge, and in_ready = 1.
- Reset:
  - Assert rst during round_idx = 1 → next cycle busy = 0, out_valid never asserted, in_ready = 1 after release.
  - A subsequent decode is correct.
- With CRYPTO_DEC_CNT_EN:
  - Preload via 65535 completed blocks; one more block → blk_count = 0x0000.
  - rst → blk_count = 0.
